systolic_feeder: RTL
====================

Name: systolic_feeder

Overview:
- Upstream stage of the 4x4 systolic MAC/activation array (sum, quantise, limit, ReLU path).
- Holds one 4x4 feature tile and one 4x4 weight tile in local registers, loaded over a simple write port.
- On `start`, emits the diagonally skewed activation streams, the staggered weight loads and a zero carry-in, cycle by cycle, so the array needs no bench-side skewing.
- Signals `busy`/`done` to the controller that sequences tiles.

Parameters:
- DATA_W, 8, width of one feature or weight element
- N, 4, array dimension (rows = cols = N); RTL must be correct for N=4, other values optional
- SUM_W, 24, width of carry_in bus to the array
- DRAIN_CYCLES, 3, zero-input cycles after the last skewed element, before done

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  tile write strobe
- wr_sel  in  1  0 = feature tile, 1 = weight tile
- wr_addr  in  4  element index row*N+col (row, col 0-based)
- wr_data  in  DATA_W  element value
- start  in  1  begin streaming the stored tiles
- busy  out  1  high from the first stream cycle until done
- done  out  1  one-cycle pulse at end of drain
- a_out  out  N*DATA_W  row activation inputs a11..a14; row r at bits [r*DATA_W +: DATA_W]
- w_out  out  N*N*DATA_W  weight inputs w11..w44; element (i,j) at index i*N+j
- w_load  out  N*N  per-weight strobe, high in the cycle w_out(i,j) is first updated
- carry_out  out  SUM_W  carry_in to array, constant 0

Behaviour:
- Reset: state IDLE, and all of the following are cleared to 0: a_out, w_out, w_load, busy, done, step counter, both tile memories. Reset dominates start and wr_en in the same cycle.
- Reset mid-stream: return to IDLE next edge with every output zeroed. No done pulse.
- Writes:
  - Accepted only in IDLE. Ignored while busy.
  - wr_addr >= N*N is ignored.
  - A write and start on the same edge: the write lands, and the stream uses the new value.
- States: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at edge E0 enters STREAM with step t=0 registered at E0. busy=1 from the cycle after E0.
- STREAM, t = 0 .. 2N-2, one step per edge:
  - a_out row r (0-based) = feat[r][t-r] when r <= t <= r+N-1, else 0.
  - w_out(i,j) loaded with weight[i][j] at t = i+j, w_load(i,j)=1 for that one cycle. Otherwise w_out holds its value and w_load is 0.
  - After t=2N-2, go to DRAIN.
- DRAIN: a_out=0 and w_out held for DRAIN_CYCLES cycles. The first drain cycle corresponds to t=2N-1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- w_out is held in IDLE after a run, so the array keeps its weights. It is cleared only by reset or overwritten by the next run.
- start while busy or in DONE is ignored, not queued.
- Total latency: start edge to done pulse = 2N-1 + DRAIN_CYCLES + 1 edges. With defaults that is 11 cycles.
- No arithmetic. Counter widths: step counter clog2(2N) bits, drain counter clog2(DRAIN_CYCLES+1) bits, no wrap-around in normal use.

Decomposition:
- Shared package `mac_pkg`:
  - DATA_W, N, SUM_W
  - state enum {IDLE, STREAM, DRAIN, DONE}
  - index helper constant N*N
- Sub-module `tile_regfile`: an N*N x DATA_W register file with one write port and a flat parallel read. Instantiate it twice, for features and weights.
- Skew/load decode stays in the top level.

Test Plan:
- Load features rows [4,0,2,1],[4,3,2,0],[4,3,0,1],[4,3,2,1] and weights rows [1,2,3,4] x4, then start.
  - Expect a_out row0 over t=0..3: 4,0,2,1.
  - Row1 over t=1..4: 4,3,2,0.
  - Row3 over t=3..6: 4,3,2,1.
  - All rows 0 at t=7..9.
  - done at edge 11.
- Same run, check weight skew:
  - w_load(0,0) only at t=0.
  - w_load(1,0) and w_load(0,1) at t=1.
  - w_load(3,3) at t=6.
  - Final w_out(i,j) = j+1 for all i.
  - carry_out = 0 throughout.
- Assert start at t=3 mid-stream, and wr_en with wr_addr=0, wr_data=9.
  - Stream is unaffected and there is no second run.
  - feat[0][0] stays 4.
- Assert reset at t=4.
  - Next cycle: a_out=0, w_out=0, busy=0, no done.
  - A subsequent start streams zeros, because memories were cleared.
- Write wr_addr=5, wr_data=7 on the same edge as start.
  - Row1 emits 7 at t=2.
- Back-to-back: assert start in the cycle after done.
  - Second run begins immediately.
  - w_out from the first run is held until reloaded at t=i+j.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, sizes and FSM state type for the systolic MAC array feed path.
package mac_pkg;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned N      = 4;
   localparam int unsigned SUM_W  = 24;
   localparam int unsigned NN     = N * N;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned STEP_W = $clog2(2 * N);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
      return row * N + col;
   endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// Tile write port, controller handshake and array-facing streams of the feeder.
interface systolic_feeder_if;
   import mac_pkg::*;

   logic                     wr_en;
   logic                     wr_sel;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     start;
   logic                     busy;
   logic                     done;
   logic [N*DATA_W-1:0]      a_out;
   logic [NN*DATA_W-1:0]     w_out;
   logic [NN-1:0]            w_load;
   logic [SUM_W-1:0]         carry_out;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, a_out, w_out, w_load, carry_out
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, a_out, w_out, w_load, carry_out
   );
endinterface

// File: rtl/systolic_feeder_tile_regfile.sv
// DEPTH x DATA_W register file: one write port, whole contents read in parallel.
module tile_regfile #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       data,
   output logic [DEPTH*DATA_W-1:0] rd_flat
);
   // Addresses at or beyond DEPTH match no entry and are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_flat <= '0;
      end else if (we) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (addr == ADDR_W'(k)) rd_flat[k*DATA_W +: DATA_W] <= data;
         end
      end
   end
endmodule

// File: rtl/systolic_feeder.sv
// Streams a stored feature/weight tile pair into the systolic array with diagonal skew.
module systolic_feeder import mac_pkg::*; #(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic            clock,
   input  logic            reset,
   systolic_feeder_if.slave bus
);
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N - 2);

   state_t               state_q, state_n;
   logic [STEP_W-1:0]    step_q, step_n;
   logic [DRAIN_W-1:0]   drain_q, drain_n;
   logic                 feat_we, wgt_we;
   logic [NN*DATA_W-1:0] feat_q, wgt_q, feat_eff, wgt_eff;
   logic [N*DATA_W-1:0]  a_n;
   logic [NN*DATA_W-1:0] w_n;
   logic [NN-1:0]        w_load_n;

   assign feat_we = bus.wr_en && (state_q == IDLE) && !bus.wr_sel;
   assign wgt_we  = bus.wr_en && (state_q == IDLE) &&  bus.wr_sel;

   tile_regfile #(.DATA_W(DATA_W), .DEPTH(NN), .ADDR_W(ADDR_W)) u_feat (
      .clock(clock), .reset(reset), .we(feat_we),
      .addr(bus.wr_addr), .data(bus.wr_data), .rd_flat(feat_q)
   );

   tile_regfile #(.DATA_W(DATA_W), .DEPTH(NN), .ADDR_W(ADDR_W)) u_wgt (
      .clock(clock), .reset(reset), .we(wgt_we),
      .addr(bus.wr_addr), .data(bus.wr_data), .rd_flat(wgt_q)
   );

   // Outputs are registered from next-state values, so a write landing on the
   // start edge is forwarded here to reach the first stream step.
   always_comb begin
      feat_eff = feat_q;
      wgt_eff  = wgt_q;
      for (int unsigned k = 0; k < NN; k++) begin
         if (bus.wr_addr == ADDR_W'(k)) begin
            if (feat_we) feat_eff[k*DATA_W +: DATA_W] = bus.wr_data;
            if (wgt_we)  wgt_eff[k*DATA_W +: DATA_W]  = bus.wr_data;
         end
      end
   end

   always_comb begin
      state_n = state_q;
      step_n  = step_q;
      drain_n = drain_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_n = STREAM;
               step_n  = '0;
            end
         end
         STREAM: begin
            step_n = step_q + 1'b1;
            if (step_q == LAST_STEP) begin
               drain_n = '0;
               state_n = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_n = DONE;
            else drain_n = drain_q + 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      int unsigned s;
      int unsigned k;
      s        = 32'(step_n);
      k        = 0;
      a_n      = '0;
      w_load_n = '0;
      w_n      = bus.w_out;
      if (state_n == STREAM) begin
         for (int unsigned r = 0; r < N; r++) begin
            if (s >= r && s < r + N)
               a_n[r*DATA_W +: DATA_W] = feat_eff[elem_idx(r, s - r)*DATA_W +: DATA_W];
         end
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               k = elem_idx(i, j);
               if (s == i + j) begin
                  w_load_n[k]             = 1'b1;
                  w_n[k*DATA_W +: DATA_W] = wgt_eff[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         step_q     <= '0;
         drain_q    <= '0;
         bus.a_out  <= '0;
         bus.w_out  <= '0;
         bus.w_load <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         state_q    <= state_n;
         step_q     <= step_n;
         drain_q    <= drain_n;
         bus.a_out  <= a_n;
         bus.w_out  <= w_n;
         bus.w_load <= w_load_n;
         bus.busy   <= (state_n == STREAM) || (state_n == DRAIN);
         bus.done   <= (state_n == DONE);
      end
   end

   assign bus.carry_out = '0;
endmodule
